// File: rtl/serial_ones_counter_pkg.sv
// Shared FSM state encoding and width helpers for the serial ones counter.
// Widths are derived from the word width W.
package serial_ones_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Number of 3-bit slices needed to cover a w-bit word.
    function automatic int chunks_f(input int w);
        return (w + 2) / 3;
    endfunction

    // Width able to hold any count in 0..w.
    function automatic int cw_f(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_ones_counter_one_count3.sv
// Combinational full-adder style ones counter: {y1,y0} = a + b + c.
// Zero latency, no state.
module one_count3 (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y1,
    output logic y0
);

    assign y0 = a ^ b ^ c;
    assign y1 = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_ones_counter.sv
// Counts the ones in a captured W-bit word, 3 bits per cycle through one shared slice.
// Fixed latency: done pulses in the cycle after edge k+CHUNKS; start is ignored while busy.
module serial_ones_counter
    import serial_ones_counter_pkg::*;
#(
    parameter int W = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [W-1:0]          data_in,
    output logic                  busy,
    output logic                  done,
    output logic [cw_f(W)-1:0]    count
);

    localparam int CHUNKS = chunks_f(W);
    localparam int CW     = cw_f(W);
    localparam int PW     = 3 * CHUNKS;
    localparam int IW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(CHUNKS - 1);

    state_e         state_q, state_d;
    logic [W-1:0]   word_q,  word_d;
    logic [IW-1:0]  idx_q,   idx_d;
    logic [CW-1:0]  acc_q,   acc_d;

    logic [PW-1:0]  word_pad;
    logic [2:0]     slice;
    logic           y1, y0;

    // Padding bits above W are zero so the last slice never adds phantom ones.
    assign word_pad = PW'(word_q);

    always_comb begin
        slice = 3'b000;
        for (int c = 0; c < CHUNKS; c++) begin
            if (idx_q == IW'(c)) begin
                slice = word_pad[3*c +: 3];
            end
        end
    end

    one_count3 u_slice (
        .a  (slice[0]),
        .b  (slice[1]),
        .c  (slice[2]),
        .y1 (y1),
        .y0 (y0)
    );

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    word_d  = data_in;
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = acc_q + CW'({y1, y0});
                idx_d = idx_q + IW'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
        end
    end

    assign busy  = (state_q != ST_IDLE);
    assign done  = (state_q == ST_DONE);
    assign count = acc_q;

endmodule

// File: tb/tb_serial_ones_counter.sv
// Randomized self-checking bench for serial_ones_counter (W=12 and W=10 instances).
module tb_serial_ones_counter;

    localparam int W      = 12;
    localparam int CHUNKS = (W + 2) / 3;
    localparam int CW     = $clog2(W + 1);
    localparam int W10    = 10;
    localparam int CH10   = (W10 + 2) / 3;
    localparam int CW10   = $clog2(W10 + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [W-1:0]    data_in;
    logic            busy;
    logic            done;
    logic [CW-1:0]   count;

    logic            start10;
    logic [W10-1:0]  data10;
    logic            busy10;
    logic            done10;
    logic [CW10-1:0] count10;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_ones_counter #(.W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .data_in (data_in),
        .busy    (busy),
        .done    (done),
        .count   (count)
    );

    serial_ones_counter #(.W(W10)) dut10 (
        .clk     (clk),
        .rst     (rst),
        .start   (start10),
        .data_in (data10),
        .busy    (busy10),
        .done    (done10),
        .count   (count10)
    );

    // Reference: population count of the word.
    function automatic int ref_ones(input logic [W-1:0] d);
        return $countones(d);
    endfunction

    // Pulses start with word d, scrambles data_in after capture, and records what happens.
    task automatic do_op(input logic [W-1:0] d, output int done_at, output int ndone,
                         output int cnt, output int busy_low_at, output int cnt0);
        done_at = -1; ndone = 0; cnt = -1; busy_low_at = -1;
        @(negedge clk); start = 1'b1; data_in = d;
        @(posedge clk);
        @(negedge clk); start = 1'b0; data_in = W'($urandom); cnt0 = int'(count);
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                if (done_at < 0) begin done_at = j; cnt = int'(count); end
            end
            if (busy === 1'b0 && busy_low_at < 0) busy_low_at = j;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; data_in = '1; start10 = 1'b1; data10 = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (count !== '0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (busy10 !== 1'b0) begin n_err++; $display("FAIL reset_busy10: got %b want 0", busy10); end
        n_cmp++; if (count10 !== '0) begin n_err++; $display("FAIL reset_count10: got %0d want 0", count10); end
        rst = 1'b0; start = 1'b0; start10 = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_after_reset: busy got %b want 0", busy); end
    endtask

    task automatic test_full();
        int da, nd, c, bl, c0;
        do_op(12'hFFF, da, nd, c, bl, c0);
        n_cmp++; if (c0 !== 0) begin n_err++; $display("FAIL full_cleared: got %0d want 0", c0); end
        n_cmp++; if (da !== CHUNKS) begin n_err++; $display("FAIL full_latency: got %0d want %0d", da, CHUNKS); end
        n_cmp++; if (nd !== 1) begin n_err++; $display("FAIL full_pulses: got %0d want 1", nd); end
        n_cmp++; if (c !== 12) begin n_err++; $display("FAIL full_count: got %0d want 12", c); end
        n_cmp++; if (bl !== CHUNKS + 1) begin n_err++; $display("FAIL full_busy_low: got %0d want %0d", bl, CHUNKS + 1); end
    endtask

    task automatic test_sparse();
        logic [W-1:0] words [2];
        int exp_cnt [2];
        int da, nd, c, bl, c0;
        words[0] = 12'h000; exp_cnt[0] = 0;
        words[1] = 12'h924; exp_cnt[1] = 4;
        for (int i = 0; i < 2; i++) begin
            do_op(words[i], da, nd, c, bl, c0);
            n_cmp++; if (da !== CHUNKS) begin n_err++; $display("FAIL sparse_latency[%0d]: got %0d want %0d", i, da, CHUNKS); end
            n_cmp++; if (c !== exp_cnt[i]) begin n_err++; $display("FAIL sparse_count[%0d]: got %0d want %0d", i, c, exp_cnt[i]); end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] d;
        int da, nd, c, bl, c0;
        for (int i = 0; i < 16; i++) begin
            d = W'($urandom);
            do_op(d, da, nd, c, bl, c0);
            n_cmp++; if (da !== CHUNKS || nd !== 1) begin n_err++; $display("FAIL rand_timing[%0d]: done at %0d x%0d want %0d x1", i, da, nd, CHUNKS); end
            n_cmp++; if (c !== ref_ones(d)) begin n_err++; $display("FAIL rand_count[%0d] d=%h: got %0d want %0d", i, d, c, ref_ones(d)); end
        end
    endtask

    task automatic test_padding();
        logic [W10-1:0] words [2];
        int da, nd, c, bl;
        words[0] = 10'h3FF;
        words[1] = W10'($urandom);
        for (int i = 0; i < 2; i++) begin
            da = -1; nd = 0; c = -1; bl = -1;
            @(negedge clk); start10 = 1'b1; data10 = words[i];
            @(posedge clk);
            @(negedge clk); start10 = 1'b0; data10 = '0;
            for (int j = 1; j <= 8; j++) begin
                @(negedge clk);
                if (done10 === 1'b1) begin
                    nd++;
                    if (da < 0) begin da = j; c = int'(count10); end
                end
                if (busy10 === 1'b0 && bl < 0) bl = j;
            end
            n_cmp++; if (da !== CH10 || nd !== 1) begin n_err++; $display("FAIL pad_timing[%0d]: done at %0d x%0d want %0d x1", i, da, nd, CH10); end
            n_cmp++; if (c !== $countones(words[i])) begin n_err++; $display("FAIL pad_count[%0d]: got %0d want %0d", i, c, $countones(words[i])); end
            n_cmp++; if (bl !== CH10 + 1) begin n_err++; $display("FAIL pad_busy_low[%0d]: got %0d want %0d", i, bl, CH10 + 1); end
        end
    endtask

    task automatic test_busy_rules();
        int da, nd, c;
        da = -1; nd = 0; c = -1;
        @(negedge clk); start = 1'b1; data_in = 12'h0F0;
        @(posedge clk);
        @(negedge clk); start = 1'b0; data_in = 12'h000;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                nd++;
                if (da < 0) begin da = j; c = int'(count); end
            end
            start = (j == 1);
        end
        start = 1'b0;
        n_cmp++; if (nd !== 1) begin n_err++; $display("FAIL busy_single_done: got %0d pulses want 1", nd); end
        n_cmp++; if (da !== CHUNKS) begin n_err++; $display("FAIL busy_latency: got %0d want %0d", da, CHUNKS); end
        n_cmp++; if (c !== 4) begin n_err++; $display("FAIL busy_count: got %0d want 4", c); end
        repeat (3) @(negedge clk);
        n_cmp++; if (count !== CW'(4)) begin n_err++; $display("FAIL idle_hold_count: got %0d want 4", count); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_hold_busy: got %b want 0", busy); end
    endtask

    task automatic test_mid_reset();
        int nd;
        nd = 0;
        @(negedge clk); start = 1'b1; data_in = 12'hFFF;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        n_cmp++; if (count !== CW'(3)) begin n_err++; $display("FAIL midrst_partial: got %0d want 3", count); end
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy); end
        n_cmp++; if (count !== '0) begin n_err++; $display("FAIL midrst_count: got %0d want 0", count); end
        for (int j = 0; j < 6; j++) begin
            if (done === 1'b1) nd++;
            @(negedge clk);
        end
        n_cmp++; if (nd !== 0) begin n_err++; $display("FAIL midrst_no_done: got %0d pulses want 0", nd); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] w [6];
        int ph, op;
        for (int i = 0; i < 6; i++) w[i] = W'($urandom);
        w[0] = 12'hFFF;
        @(negedge clk); start = 1'b1; data_in = w[0];
        @(posedge clk);
        for (int t = 0; t < 5 * (CHUNKS + 2); t++) begin
            @(negedge clk);
            ph = t % (CHUNKS + 2);
            op = t / (CHUNKS + 2);
            if (ph == 0) data_in = w[op + 1];
            n_cmp++;
            if (done !== (ph == CHUNKS) || busy !== (ph != CHUNKS + 1)) begin
                n_err++;
                $display("FAIL b2b_ctrl t=%0d: done=%b busy=%b want done=%b busy=%b",
                         t, done, busy, (ph == CHUNKS), (ph != CHUNKS + 1));
            end
            if (ph == CHUNKS) begin
                n_cmp++;
                if (int'(count) !== ref_ones(w[op])) begin
                    n_err++;
                    $display("FAIL b2b_count op=%0d: got %0d want %0d", op, count, ref_ones(w[op]));
                end
            end
        end
        start = 1'b0;
        repeat (CHUNKS + 3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_full();
        test_sparse();
        test_random();
        test_padding();
        test_busy_rules();
        test_mid_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_ones_counter.md
SERIAL_ONES_COUNTER -- requirements
Module: serial_ones_counter

Interface
REQ-001 Parameter: W, default 12, data word width in bits (W >= 3).
REQ-002 Derived constant: CHUNKS = ceil(W/3), number of 3-bit slices per word.
REQ-003 Derived constant: CW = clog2(W+1), width of the count output.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request to count the ones in data_in; sampled only in IDLE.
REQ-007 data_in  input  W  word to count; captured on the edge that accepts start.
REQ-008 busy  output  1  high in RUN and DONE states.
REQ-009 done  output  1  one-cycle pulse; count is final while high.
REQ-010 count  output  CW  number of ones in the captured word.

Function
REQ-011 The block SHALL be a three-state FSM (IDLE, RUN, DONE) that time-shares one 3-input ones-counter slice across the captured word.
REQ-012 In IDLE with start=1 at edge k, the block SHALL capture data_in, clear the accumulator and chunk index to 0, and enter RUN.
REQ-013 In IDLE with start=0, the block SHALL hold all state, and count SHALL keep its last value.
REQ-014 On each RUN edge, the block SHALL feed bits [3*idx+2 : 3*idx] of the captured word into the slice, with bit positions >= W forced to 0.
REQ-015 On each RUN edge, the block SHALL add the slice's 2-bit result, zero-extended, to the accumulator, and increment idx.
REQ-016 When idx = CHUNKS-1 is processed (edge k+CHUNKS), the block SHALL enter DONE.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle, after which the block SHALL return to IDLE on the next edge.
REQ-018 Latency SHALL be fixed: done is high in the cycle following edge k+CHUNKS, independent of data.
REQ-019 count SHALL equal the accumulator at all times; it is final from DONE until the next accepted start clears it.
REQ-020 start asserted in RUN or DONE SHALL be ignored, with no queuing; a start held high through DONE SHALL be accepted on the first IDLE edge.
REQ-021 The accumulator SHALL never overflow: the maximum value W fits in CW bits by construction.
REQ-022 Changes to data_in after capture SHALL NOT affect the result.

Reset
REQ-023 On rst=1 at a rising edge, the block SHALL go to IDLE with accumulator=0, idx=0, captured word=0, busy=0, done=0 and count=0, regardless of state.
REQ-024 rst asserted mid-RUN SHALL abort the operation without a done pulse.
REQ-025 rst SHALL take priority over a simultaneous start.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding (IDLE, RUN, DONE) and the CHUNKS and CW width helper functions.
REQ-027 The 3-input ones-counter slice SHALL be a separate combinational sub-module, one_count3 (a, b, c -> y1, y0, where {y1,y0} = a+b+c), instantiated once.
REQ-028 The FSM, index, accumulator and capture register SHALL reside in serial_ones_counter.

Verification
REQ-029 Full word: W=12, data_in=0xFFF, start pulse at edge k -> done high in the cycle after edge k+4, count=12, busy low after edge k+5.
REQ-030 Empty and sparse words: data_in=0x000 -> count=0; data_in=0x924 -> count=4; both with the same 4-cycle latency.
REQ-031 Padding: W=10, data_in=10'h3FF -> CHUNKS=4, count=10, with no contribution from padded bits.
REQ-032 Busy and data rules: start re-pulsed mid-RUN and data_in changed to 0x000 after capture of 0x0F0 -> single done pulse, count=4.
REQ-033 Reset and back-to-back: rst asserted during the 2nd RUN cycle of 0xFFF -> IDLE and count=0 next cycle, no done pulse; then start held high continuously -> operations repeat every CHUNKS+2 cycles with correct counts.
